// File: rtl/instr_mem_writer_if.sv
// Host/loader word stream plus instruction-memory byte write port for instr_mem_writer.
// Ports: start/base_addr open a session; word_valid/word_ready handshake carries word_data/word_last.
//        mem_we/mem_addr/mem_wdata drive the byte-wide memory; busy/done/err_*/word_count report status.
interface instr_mem_writer_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_last;
  logic              word_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
  logic              err_ovf;
  logic              err_align;
  logic [ADDR_W-1:0] word_count;

  // Host / loader side
  modport master (
    output start, base_addr, word_valid, word_data, word_last,
    input  word_ready, mem_we, mem_addr, mem_wdata, busy, done,
           err_ovf, err_align, word_count
  );

  // Writer side
  modport slave (
    input  start, base_addr, word_valid, word_data, word_last,
    output word_ready, mem_we, mem_addr, mem_wdata, busy, done,
           err_ovf, err_align, word_count
  );
endinterface

// File: rtl/instr_mem_writer.sv
// Splits each accepted 32-bit word into 4 big-endian byte writes (MSB at lowest address).
// Latency: first mem_we the cycle after the handshake; done 5 cycles after the last handshake.
// Backpressure: word_ready only in WAIT, so at most one word per 5 cycles is accepted.
//
// Ports: clk, rst (async, active high); bus (instr_mem_writer_if.slave) carries the word
// stream, the memory byte write port and the status outputs.
// Optional feature: define INSTR_MEM_WRITER_ALIGN_CHECK_EN to reject bases with
// base_addr[1:0] != 0 (err_align set, session not started). Otherwise err_align is 0.
module instr_mem_writer #(
  parameter int MEM_BYTES = 400,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_writer_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WR0, S_WR1, S_WR2, S_WR3, S_FIN
  } state_t;

  // Highest legal byte address, one bit wider than the pointer so ptr+3 cannot wrap.
  localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word_q;
  logic              last_q;
  logic [ADDR_W-1:0] word_count_q;
  logic              err_ovf_q;
  logic              done_pend;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;

  logic              start_ok;
  logic              hs;
  logic              ovf;
  logic              wr_next;
  logic [1:0]        off_next;
  logic [7:0]        byte_next;
  logic [ADDR_W:0]   end_addr;
  logic              fits;

  assign end_addr = {1'b0, ptr} + (ADDR_W+1)'(3);
  assign fits     = (end_addr <= LAST_BYTE);

`ifdef INSTR_MEM_WRITER_ALIGN_CHECK_EN
  logic align_bad;
  logic err_align_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state, handshake/error strobes, and the byte that the next cycle will write.
  always_comb begin
    next_state = state;
    start_ok   = 1'b0;
    hs         = 1'b0;
    ovf        = 1'b0;
    wr_next    = 1'b0;
    off_next   = 2'd0;
    byte_next  = 8'h00;
`ifdef INSTR_MEM_WRITER_ALIGN_CHECK_EN
    align_bad  = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (bus.start) begin
`ifdef INSTR_MEM_WRITER_ALIGN_CHECK_EN
          if (bus.base_addr[1:0] != 2'b00) begin
            align_bad = 1'b1;
          end else begin
            start_ok   = 1'b1;
            next_state = S_WAIT;
          end
`else
          start_ok   = 1'b1;
          next_state = S_WAIT;
`endif
        end
      end
      S_WAIT: begin
        if (bus.word_valid) begin
          hs = 1'b1;
          if (fits) begin
            next_state = S_WR0;
          end else begin
            // Word would run past the end of memory: drop it and end without done.
            ovf        = 1'b1;
            next_state = S_FIN;
          end
        end
      end
      S_WR0:   next_state = S_WR1;
      S_WR1:   next_state = S_WR2;
      S_WR2:   next_state = S_WR3;
      S_WR3:   next_state = last_q ? S_FIN : S_WAIT;
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    // Memory outputs are registered, so they are computed from next_state.
    // WR0 is only entered from a handshake, hence it takes the byte straight from the bus.
    case (next_state)
      S_WR0: begin wr_next = 1'b1; off_next = 2'd0; byte_next = bus.word_data[31:24]; end
      S_WR1: begin wr_next = 1'b1; off_next = 2'd1; byte_next = word_q[23:16]; end
      S_WR2: begin wr_next = 1'b1; off_next = 2'd2; byte_next = word_q[15:8]; end
      S_WR3: begin wr_next = 1'b1; off_next = 2'd3; byte_next = word_q[7:0]; end
      default: ;
    endcase
  end

  // Datapath: pointer, word latch, counters, flags and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= '0;
      word_q       <= '0;
      last_q       <= 1'b0;
      word_count_q <= '0;
      err_ovf_q    <= 1'b0;
      done_pend    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // Only a normal WR3 -> FIN exit arms done; the overflow path reaches FIN from WAIT.
      done_pend <= (state == S_WR3) && last_q;
      mem_we_q  <= wr_next;
      if (wr_next) begin
        mem_addr_q  <= ptr + ADDR_W'(off_next);
        mem_wdata_q <= byte_next;
      end
      if (start_ok) begin
        ptr          <= bus.base_addr;
        word_count_q <= '0;
        err_ovf_q    <= 1'b0;
      end
      if (hs) begin
        word_q <= bus.word_data;
        last_q <= bus.word_last;
      end
      if (ovf) err_ovf_q <= 1'b1;
      if (state == S_WR3) begin
        ptr          <= ptr + ADDR_W'(4);
        word_count_q <= word_count_q + ADDR_W'(1);
      end
    end
  end

`ifdef INSTR_MEM_WRITER_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_align_q <= 1'b0;
    else if (start_ok)  err_align_q <= 1'b0;
    else if (align_bad) err_align_q <= 1'b1;
  end
  assign bus.err_align = err_align_q;
`else
  assign bus.err_align = 1'b0;
`endif

  assign bus.word_ready = (state == S_WAIT);
  assign bus.busy       = (state != S_IDLE) && (state != S_FIN);
  assign bus.done       = (state == S_FIN) && done_pend;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed bench for instr_mem_writer: table of single-word sessions plus hand-written
// sequences for latency, streaming, overflow, reset mid-word, START while busy and alignment.
module tb_instr_mem_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_mem_writer_if #(.ADDR_W(32)) bus ();

  instr_mem_writer #(.MEM_BYTES(400), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Write log and event counters, owned solely by the monitor.
  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  int          done_cnt  = 0;
  int          ready_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
    if (bus.done)       done_cnt++;
    if (bus.word_ready) ready_cnt++;
  end

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      data;
    int               exp_nwr;
    logic [31:0]      exp_a0;
    logic [0:3][7:0]  eb;
    int               exp_done;
    logic             exp_ovf;
    int               exp_cnt;
  } vec_t;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] base);
    bus.start     = 1'b1;
    bus.base_addr = base;
    tick();
    bus.start     = 1'b0;
  endtask

  // Offers one word and returns one time unit after the handshake edge.
  task automatic send_word(input logic [31:0] data, input logic last, output bit ok);
    ok             = 1'b0;
    bus.word_valid = 1'b1;
    bus.word_data  = data;
    bus.word_last  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.word_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.word_valid = 1'b0;
    check("handshake", ok, 1);
  endtask

  task automatic check_writes(input string nm, input int b_w, input int n,
                              input logic [31:0] a0, input logic [0:3][7:0] eb,
                              input int word_idx);
    for (int i = 0; i < n; i++) begin
      if (b_w + i < wa.size()) begin
        check({nm, "_addr"}, wa[b_w+i], a0 + 32'(i));
        check({nm, "_data"}, wd[b_w+i], eb[i]);
      end else begin
        check({nm, "_missing_write"}, word_idx, -1);
      end
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int b_w, b_d;
    bit ok;
    b_w = wa.size();
    b_d = done_cnt;
    do_start(v.base);
    send_word(v.data, 1'b1, ok);
    repeat (8) tick();
    check({nm, "_nwr"}, wa.size() - b_w, v.exp_nwr);
    if (v.exp_nwr == 4) check_writes(nm, b_w, 4, v.exp_a0, v.eb, 0);
    check({nm, "_done"}, done_cnt - b_d, v.exp_done);
    check({nm, "_ovf"}, bus.err_ovf, v.exp_ovf);
    check({nm, "_cnt"}, bus.word_count, v.exp_cnt);
    check({nm, "_busy"}, bus.busy, 0);
  endtask

  vec_t vecs[4];

  initial begin
    int b_w, b_d, b_r, done_at;
    bit ok;
    logic [31:0] sw[3];
    vec_t post;

    vecs[0] = '{32'd16,        32'hDEADBEEF, 4, 32'd16,  {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1, 1'b0, 1};
    vecs[1] = '{32'd396,       32'hA1B2C3D4, 4, 32'd396, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1, 1'b0, 1};
    vecs[2] = '{32'd400,       32'h01020304, 0, 32'd0,   {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 0};
    vecs[3] = '{32'hFFFFFFFC,  32'h55AA55AA, 0, 32'd0,   {8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 0};

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_last  = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.word_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnt", bus.word_count, 0);
    check("rst_ovf", bus.err_ovf, 0);
    check("rst_align", bus.err_align, 0);
    rst = 1'b0;
    tick();

    // Single word at base 0: byte order, first-write latency and done at cycle 5.
    b_w = wa.size();
    do_start(32'd0);
    check("wait_busy", bus.busy, 1);
    check("wait_ready", bus.word_ready, 1);
    send_word(32'h8C220004, 1'b1, ok);
    done_at = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) check("first_we", bus.mem_we, 1);
      if (bus.done && done_at == 0) done_at = c;
    end
    check("done_latency", done_at, 5);
    check_writes("single", b_w, 4, 32'd0, {8'h8C, 8'h22, 8'h00, 8'h04}, 0);
    check("single_cnt", bus.word_count, 1);
    tick();

    // Table of single-word sessions
    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Stream of 3 words, valid held high
    sw[0] = 32'h11223344; sw[1] = 32'h55667788; sw[2] = 32'h99AABBCC;
    b_w = wa.size(); b_d = done_cnt; b_r = ready_cnt;
    do_start(32'd8);
    bus.word_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.word_data = sw[k];
      bus.word_last = (k == 2);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (bus.word_ready) begin
          @(posedge clk);
          #1;
          ok = 1'b1;
        end
      end
      check("stream_hs", ok, 1);
    end
    bus.word_valid = 1'b0;
    repeat (8) tick();
    check("stream_nwr", wa.size() - b_w, 12);
    check_writes("stream_w0", b_w,     4, 32'd8,  {8'h11, 8'h22, 8'h33, 8'h44}, 0);
    check_writes("stream_w1", b_w + 4, 4, 32'd12, {8'h55, 8'h66, 8'h77, 8'h88}, 1);
    check_writes("stream_w2", b_w + 8, 4, 32'd16, {8'h99, 8'hAA, 8'hBB, 8'hCC}, 2);
    check("stream_ready_cycles", ready_cnt - b_r, 3);
    check("stream_done", done_cnt - b_d, 1);
    check("stream_cnt", bus.word_count, 3);

    // Overflow on the second word from base 396
    b_w = wa.size(); b_d = done_cnt;
    do_start(32'd396);
    send_word(32'h0A0B0C0D, 1'b0, ok);
    send_word(32'hFFFFFFFF, 1'b1, ok);
    repeat (8) tick();
    check("ovf_nwr", wa.size() - b_w, 4);
    check_writes("ovf", b_w, 4, 32'd396, {8'h0A, 8'h0B, 8'h0C, 8'h0D}, 0);
    check("ovf_flag", bus.err_ovf, 1);
    check("ovf_done", done_cnt - b_d, 0);
    check("ovf_cnt", bus.word_count, 1);

    // START while busy is ignored
    b_w = wa.size(); b_d = done_cnt;
    do_start(32'd20);
    send_word(32'hCAFEBABE, 1'b0, ok);
    tick(); tick();
    check("busy_start_in_wr2", bus.mem_addr, 32'd22);
    bus.start = 1'b1; bus.base_addr = 32'd100;
    tick();
    bus.start = 1'b0;
    send_word(32'h12345678, 1'b1, ok);
    repeat (8) tick();
    check("busy_start_nwr", wa.size() - b_w, 8);
    check_writes("busy_start_w0", b_w,     4, 32'd20, {8'hCA, 8'hFE, 8'hBA, 8'hBE}, 0);
    check_writes("busy_start_w1", b_w + 4, 4, 32'd24, {8'h12, 8'h34, 8'h56, 8'h78}, 1);
    check("busy_start_cnt", bus.word_count, 2);
    check("busy_start_done", done_cnt - b_d, 1);

    // Reset during WR1
    do_start(32'd40);
    send_word(32'h0F0E0D0C, 1'b1, ok);
    tick();
    check("pre_rst_we", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    check("midrst_we", bus.mem_we, 0);
    check("midrst_addr", bus.mem_addr, 0);
    check("midrst_data", bus.mem_wdata, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_cnt", bus.word_count, 0);
    tick();
    rst = 1'b0;
    b_w = wa.size(); b_d = done_cnt;
    repeat (8) tick();
    check("midrst_no_writes", wa.size() - b_w, 0);
    check("midrst_no_done", done_cnt - b_d, 0);
    post = '{32'd60, 32'h0BADF00D, 4, 32'd60, {8'h0B, 8'hAD, 8'hF0, 8'h0D}, 1, 1'b0, 1};
    run_vec("post_rst", post);

    // Unaligned base
`ifdef INSTR_MEM_WRITER_ALIGN_CHECK_EN
    b_w = wa.size(); b_d = done_cnt;
    do_start(32'd2);
    check("align_flag", bus.err_align, 1);
    check("align_busy", bus.busy, 0);
    bus.word_valid = 1'b1; bus.word_data = 32'h01020304; bus.word_last = 1'b1;
    repeat (8) tick();
    bus.word_valid = 1'b0;
    check("align_nwr", wa.size() - b_w, 0);
    check("align_done", done_cnt - b_d, 0);
`else
    post = '{32'd2, 32'h01020304, 4, 32'd2, {8'h01, 8'h02, 8'h03, 8'h04}, 1, 1'b0, 1};
    run_vec("unaligned", post);
    check("unaligned_flag", bus.err_align, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected bench to finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_mem_writer.md
Name: instr_mem_writer

Overview:
- Programs the byte-wide instruction memory from a 32-bit word stream, for example a boot loader or debug link.
- Each accepted word is split into 4 byte writes, big-endian: the MSB goes to the lowest address. This matches the fetch path, which reads {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- Sits between the host or loader interface and the instruction memory write port.

Parameters:
- MEM_BYTES, 400, instruction memory size in bytes; valid byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 32, width of the address buses.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse that begins a load session at BASE_ADDR.
- BASE_ADDR  in  ADDR_W  first byte address of the session.
- WORD_VALID  in  1  WORD_DATA and WORD_LAST are valid.
- WORD_DATA  in  32  instruction word.
- WORD_LAST  in  1  marks the final word of the session.
- WORD_READY  out  1  writer can accept a word this cycle.
- MEM_WE  out  1  byte write strobe.
- MEM_ADDR  out  ADDR_W  byte address.
- MEM_WDATA  out  8  byte data.
- BUSY  out  1  session in progress.
- DONE  out  1  one-cycle pulse when a session ends normally.
- ERR_OVF  out  1  sticky flag: a word would exceed memory bounds.
- ERR_ALIGN  out  1  sticky flag: misaligned start (optional feature only).
- WORD_COUNT  out  ADDR_W  number of words written in the current or last session.

Behaviour:
- Reset: RST high forces all outputs, the FSM, the address pointer and the word latch to 0 / IDLE immediately, without waiting for a clock edge.
- Reset mid-write: any remaining bytes of the current word are abandoned.
- States: IDLE, WAIT, WR0, WR1, WR2, WR3, FIN.
- IDLE:
  - BUSY=0, WORD_READY=0.
  - START=1 → load ptr=BASE_ADDR, clear WORD_COUNT, ERR_OVF and ERR_ALIGN, go to WAIT.
- WAIT:
  - BUSY=1, WORD_READY=1.
  - A handshake occurs when WORD_VALID and WORD_READY are both high on a rising edge. On handshake, latch WORD_DATA and WORD_LAST.
  - If ptr+3 <= MEM_BYTES-1 (compare at ADDR_W+1 bits, no wrap) → go to WR0.
  - Otherwise drop the word, set ERR_OVF, go to FIN without a DONE pulse.
- WR0..WR3:
  - One byte per cycle; WORD_READY=0; MEM_WE=1.
  - MEM_ADDR: WR0=ptr, WR1=ptr+1, WR2=ptr+2, WR3=ptr+3.
  - MEM_WDATA: WR0=[31:24], WR1=[23:16], WR2=[15:8], WR3=[7:0].
  - After WR3: ptr+=4 and WORD_COUNT+=1. If the latched LAST=1 go to FIN with DONE pending; otherwise go to WAIT.
- FIN:
  - DONE=1 for exactly one cycle, only on a normal end.
  - BUSY=0; return to IDLE.
- Throughput and latency:
  - Maximum throughput is 1 word per 5 cycles.
  - The first MEM_WE is asserted the cycle after the handshake.
- Outputs and rules:
  - MEM_WE, MEM_ADDR and MEM_WDATA are registered.
  - MEM_ADDR and MEM_WDATA hold their last values when MEM_WE=0.
  - START while BUSY=1 is ignored.
  - START in the same cycle as DONE is ignored (the FSM is in FIN).
  - WORD_VALID outside WAIT is not consumed.
  - The error flags stay set until the next accepted START or RST.

Optional Feature:
- Macro: INSTR_MEM_WRITER_ALIGN_CHECK_EN.
- When defined: START with BASE_ADDR[1:0]!=0 sets ERR_ALIGN, writes nothing and stays in IDLE. BUSY stays 0 and there is no DONE pulse.
- When not defined: unaligned bases are accepted and written byte-exact, and ERR_ALIGN is tied to 0.

Test Plan:
- Single word: START with BASE_ADDR=0, then word 0x8C220004 with LAST=1.
  → Bytes written: addr 0=0x8C, 1=0x22, 2=0x00, 3=0x04.
  → DONE pulses 5 cycles after the handshake; WORD_COUNT=1.
- Stream of 3 words from base 8, WORD_VALID held high: 0x11223344, 0x55667788, 0x99AABBCC (last).
  → Writes 8..19 in order; WORD_READY high only in WAIT; WORD_COUNT=3.
- Overflow: base=396, first word OK, second word offered.
  → Bytes 396..399 written; second word produces no MEM_WE; ERR_OVF=1; no DONE.
- Reset mid-word: assert RST during WR1.
  → MEM_WE=0 immediately; all outputs 0; no further writes.
  → A later START works normally.
- START while BUSY: pulse START with BASE_ADDR=100 during WR2.
  → Ignored; the pointer continues from the original base.
- Macro defined: START with BASE_ADDR=2.
  → ERR_ALIGN=1, BUSY stays 0, no writes.
  → Without the macro, bytes go to 2..5.
